// File: rtl/mmss_scan_timer_pkg.sv
// Shared types, constants and BCD helpers for the MM:SS scan timer.
package mmss_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int BCD_W = 8;

  // Active-high segment patterns, bit 6 = a ... bit 0 = g.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
    7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
  };

  typedef struct packed {
    logic [BCD_W-1:0] mm;
    logic [BCD_W-1:0] ss;
  } count_t;

  localparam count_t CNT_ZERO = '{mm: 8'h00, ss: 8'h00};
  localparam count_t CNT_MAX  = '{mm: 8'h59, ss: 8'h59};

  function automatic logic bcd60_ok(input logic [BCD_W-1:0] b);
    return (b[7:4] <= 4'd5) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [BCD_W-1:0] bcd60_inc(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    if (b[3:0] != 4'd9)
      r = {b[7:4], b[3:0] + 4'd1};
    else if (b[7:4] != 4'd5)
      r = {b[7:4] + 4'd1, 4'd0};
    else
      r = 8'h00;
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] bcd60_dec(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    if (b[3:0] != 4'd0)
      r = {b[7:4], b[3:0] - 4'd1};
    else if (b[7:4] != 4'd0)
      r = {b[7:4] - 4'd1, 4'd9};
    else
      r = 8'h59;
    return r;
  endfunction

  // One-second step of the whole MM:SS value; seconds carry/borrow into minutes.
  function automatic count_t count_step(input count_t c, input logic down);
    count_t r;
    r = c;
    if (!down) begin
      r.ss = bcd60_inc(c.ss);
      if (c.ss == 8'h59) r.mm = bcd60_inc(c.mm);
    end else begin
      r.ss = bcd60_dec(c.ss);
      if (c.ss == 8'h00) r.mm = bcd60_dec(c.mm);
    end
    return r;
  endfunction

  function automatic count_t count_term(input logic down);
    return down ? CNT_ZERO : CNT_MAX;
  endfunction

endpackage

// File: rtl/mmss_scan_timer_if.sv
// Command, preset and display signals of the MM:SS scan timer.
interface mmss_scan_timer_if;
  import mmss_timer_pkg::*;

  logic             start;
  logic             stop;
  logic             clear;
  logic             load;
  logic [BCD_W-1:0] load_mm;
  logic [BCD_W-1:0] load_ss;
  logic             dir;
  logic [6:0]       seg;
  logic             dp;
  logic [3:0]       an;
  logic [BCD_W-1:0] mm;
  logic [BCD_W-1:0] ss;
  logic             running;
  logic             done;
  logic             err;

  modport master (
    output start, stop, clear, load, load_mm, load_ss, dir,
    input  seg, dp, an, mm, ss, running, done, err
  );

  modport slave (
    input  start, stop, clear, load, load_mm, load_ss, dir,
    output seg, dp, an, mm, ss, running, done, err
  );

endinterface

// File: rtl/mmss_scan_timer_seg7_decode.sv
// Nibble to active-high seven-segment pattern; non-decimal nibbles blank.
module seg7_decode
  import mmss_timer_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  always_comb begin
    pat = 7'h00;
    if (nib <= 4'd9) pat = SEG_TABLE[nib];
  end

endmodule

// File: rtl/mmss_scan_timer.sv
// MM:SS up/down timer with multiplexed four-digit seven-segment scan output.
//
// state    | meaning
// ST_IDLE  | stopped, count held, waiting for start
// ST_RUN   | prescaler running, count steps on each tick
// ST_PAUSE | stopped mid-run, prescaler phase kept, dp blinks
// ST_DONE  | terminal value reached, count frozen until clear/load
module mmss_scan_timer
  import mmss_timer_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 1,
  parameter int SCAN_HZ        = 1000,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               arst,
  mmss_scan_timer_if.slave   bus
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam int SW       = $clog2(SCAN_DIV);

  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] BLINK_HALF = PW'(TICK_DIV / 2);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  localparam logic       SEG_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic       AN_LOW  = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_OFF = SEG_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_LOW;
  localparam logic [3:0] AN_OFF  = AN_LOW ? 4'hF : 4'h0;

  state_e         state_q, state_d;
  count_t         cnt_q, cnt_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           err_q, err_d;

  count_t         load_val;
  count_t         cnt_next;
  count_t         cnt_term;
  logic           load_ok;
  logic           tick;

  assign load_val = '{mm: bus.load_mm, ss: bus.load_ss};
  assign load_ok  = bcd60_ok(bus.load_mm) && bcd60_ok(bus.load_ss);
  assign tick     = (state_q == ST_RUN) && (presc_q == TICK_LAST);
  assign cnt_next = count_step(cnt_q, bus.dir);
  assign cnt_term = count_term(bus.dir);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      presc_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      err_q   <= err_d;
    end
  end

  // Commands are mutually exclusive by priority; the tick path only runs
  // when no command is present, so clear/load/stop all freeze the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    err_d   = 1'b0;
    if (bus.clear) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
      presc_d = '0;
    end else if (bus.load) begin
      if (load_ok) begin
        state_d = ST_IDLE;
        cnt_d   = load_val;
        presc_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (bus.start && (state_q == ST_IDLE)) begin
      state_d = ST_RUN;
      presc_d = '0;
    end else if (bus.start && (state_q == ST_PAUSE)) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        presc_d = '0;
        // Already terminal (e.g. started at the end value): finish without moving.
        if (cnt_q == cnt_term) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_next;
          if (cnt_next == cnt_term) state_d = ST_DONE;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  assign bus.mm      = cnt_q.mm;
  assign bus.ss      = cnt_q.ss;
  assign bus.running = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.err     = err_q;

  logic [SW-1:0] scan_q;
  logic [1:0]    digit_q;
  logic [PW-1:0] blink_q;

  // Scan and blink timebases free-run in every state.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      scan_q  <= '0;
      digit_q <= 2'd0;
      blink_q <= '0;
    end else begin
      if (scan_q == SCAN_LAST) begin
        scan_q  <= '0;
        digit_q <= digit_q + 2'd1;
      end else begin
        scan_q <= scan_q + SW'(1);
      end
      if (blink_q == TICK_LAST)
        blink_q <= '0;
      else
        blink_q <= blink_q + PW'(1);
    end
  end

  logic [3:0] dig_val;
  logic [6:0] seg_pat;
  logic [3:0] an_sel;
  logic       dp_lit;

  always_comb begin
    dig_val = 4'd0;
    case (digit_q)
      2'd0: dig_val = cnt_q.ss[3:0];
      2'd1: dig_val = cnt_q.ss[7:4];
      2'd2: dig_val = cnt_q.mm[3:0];
      2'd3: dig_val = cnt_q.mm[7:4];
      default: dig_val = 4'd0;
    endcase
  end

  seg7_decode u_seg7_decode (
    .nib (dig_val),
    .pat (seg_pat)
  );

  assign an_sel = 4'b0001 << digit_q;
  assign dp_lit = (digit_q == 2'd2) && ((state_q != ST_PAUSE) || (blink_q < BLINK_HALF));

  logic [6:0] seg_q;
  logic       dp_q;
  logic [3:0] an_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= SEG_LOW ? ~seg_pat : seg_pat;
      dp_q  <= SEG_LOW ? ~dp_lit  : dp_lit;
      an_q  <= AN_LOW  ? ~an_sel  : an_sel;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_mmss_scan_timer.sv
// Directed bench for mmss_scan_timer with a cycle-level behavioural model.
module tb_mmss_scan_timer;

  localparam int TDIV    = 20;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clk  = 1'b0;
  logic arst = 1'b0;

  mmss_scan_timer_if bus();

  mmss_scan_timer #(
    .CLK_HZ         (20),
    .TICK_HZ        (1),
    .SCAN_HZ        (5),
    .AN_ACTIVE_LOW  (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [6:0] seg_on(input int n);
    case (n)
      0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
      4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
      8: return 7'h7F;  9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  // Model: count held as total seconds, display derived from cycles since reset.
  int         m_st  = S_IDLE;
  int         m_tot = 0;
  int         m_pre = 0;
  int         m_k   = 0;
  logic       m_err = 1'b0;
  logic [3:0] e_an  = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp  = 1'b1;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_st = S_IDLE; m_tot = 0; m_pre = 0; m_k = 0; m_err = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      int d, nib, term, mins, secs;
      d    = (m_k / 4) % 4;
      mins = m_tot / 60;
      secs = m_tot % 60;
      case (d)
        0: nib = secs % 10;
        1: nib = secs / 10;
        2: nib = mins % 10;
        default: nib = mins / 10;
      endcase
      e_an  = ~(4'b0001 << d);
      e_seg = ~seg_on(nib);
      e_dp  = !((d == 2) && ((m_st != S_PAUSE) || ((m_k % TDIV) < TDIV / 2)));
      m_k++;
      m_err = 1'b0;
      if (bus.clear) begin
        m_st = S_IDLE; m_tot = 0; m_pre = 0;
      end else if (bus.load) begin
        if (bus.load_mm[7:4] <= 5 && bus.load_mm[3:0] <= 9 &&
            bus.load_ss[7:4] <= 5 && bus.load_ss[3:0] <= 9) begin
          m_tot = from_bcd(bus.load_mm) * 60 + from_bcd(bus.load_ss);
          m_st  = S_IDLE; m_pre = 0;
        end else begin
          m_err = 1'b1;
        end
      end else if (bus.stop) begin
        if (m_st == S_RUN) m_st = S_PAUSE;
      end else if (bus.start && m_st == S_IDLE) begin
        m_st = S_RUN; m_pre = 0;
      end else if (bus.start && m_st == S_PAUSE) begin
        m_st = S_RUN;
      end else if (m_st == S_RUN) begin
        if (m_pre == TDIV - 1) begin
          m_pre = 0;
          term  = bus.dir ? 0 : 3599;
          if (m_tot != term) m_tot = m_tot + (bus.dir ? -1 : 1);
          if (m_tot == term) m_st = S_DONE;
        end else begin
          m_pre++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("mm",      bus.mm,      to_bcd(m_tot / 60));
    chk("ss",      bus.ss,      to_bcd(m_tot % 60));
    chk("running", bus.running, m_st == S_RUN);
    chk("done",    bus.done,    m_st == S_DONE);
    chk("err",     bus.err,     m_err);
    chk("an",      bus.an,      e_an);
    chk("seg",     bus.seg,     e_seg);
    chk("dp",      bus.dp,      e_dp);
  end

  task automatic do_load(input logic [7:0] mm, input logic [7:0] ss);
    bus.load_mm = mm; bus.load_ss = ss; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; @(negedge clk); bus.stop = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1; @(negedge clk); bus.clear = 1'b0;
  endtask

  initial begin
    bit         found;
    logic [3:0] prev_an;
    bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0;
    bus.load_mm = 8'h00; bus.load_ss = 8'h00; bus.dir = 1'b0;
    #1 arst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an",  bus.an,  4'hF);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_dp",  bus.dp,  1'b1);
    chk("rst_cnt", {bus.mm, bus.ss}, 16'h0000);
    arst = 1'b0;

    // Up-count with carry into minutes.
    do_load(8'h00, 8'h58);
    bus.dir = 1'b0;
    pulse_start();
    repeat (19) @(negedge clk);
    chk("up_19_ss", bus.ss, 8'h58);
    @(negedge clk);
    chk("up_20_ss", bus.ss, 8'h59);
    chk("model_up_20", to_bcd(m_tot % 60), 8'h59);
    repeat (20) @(negedge clk);
    chk("up_40_cnt", {bus.mm, bus.ss}, 16'h0100);
    chk("up_40_done", bus.done, 1'b0);
    chk("up_40_run", bus.running, 1'b1);

    // Down-count to zero, then start is ignored in DONE.
    do_load(8'h00, 8'h02);
    bus.dir = 1'b1;
    pulse_start();
    repeat (40) @(negedge clk);
    chk("dn_40_cnt", {bus.mm, bus.ss}, 16'h0000);
    chk("dn_40_done", bus.done, 1'b1);
    chk("dn_40_run", bus.running, 1'b0);
    pulse_start();
    repeat (25) @(negedge clk);
    chk("done_hold_cnt", {bus.mm, bus.ss}, 16'h0000);
    chk("done_hold_done", bus.done, 1'b1);

    // Start already at the down terminal: DONE on the next tick, count kept.
    do_load(8'h00, 8'h00);
    pulse_start();
    repeat (19) @(negedge clk);
    chk("term_pre_run", bus.running, 1'b1);
    @(negedge clk);
    chk("term_done", bus.done, 1'b1);
    chk("term_cnt", {bus.mm, bus.ss}, 16'h0000);

    // Up to 59:59 and borrow from minutes.
    do_load(8'h59, 8'h58);
    bus.dir = 1'b0;
    pulse_start();
    repeat (20) @(negedge clk);
    chk("max_cnt", {bus.mm, bus.ss}, 16'h5959);
    chk("max_done", bus.done, 1'b1);
    do_load(8'h01, 8'h00);
    bus.dir = 1'b1;
    pulse_start();
    repeat (20) @(negedge clk);
    chk("borrow_cnt", {bus.mm, bus.ss}, 16'h0059);
    chk("model_borrow", to_bcd(m_tot / 60), 8'h00);

    // Rejected loads.
    do_load(8'h12, 8'h34);
    bus.load_mm = 8'h12; bus.load_ss = 8'h60; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("bad_ss_err", bus.err, 1'b1);
    chk("bad_ss_cnt", {bus.mm, bus.ss}, 16'h1234);
    @(negedge clk);
    chk("bad_ss_err_end", bus.err, 1'b0);
    bus.load_mm = 8'h0A; bus.load_ss = 8'h00; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("bad_mm_err", bus.err, 1'b1);
    chk("bad_mm_cnt", {bus.mm, bus.ss}, 16'h1234);
    @(negedge clk);

    // Pause keeps prescaler phase.
    pulse_clear();
    bus.dir = 1'b0;
    pulse_start();
    repeat (10) @(negedge clk);
    pulse_stop();
    chk("pause_run", bus.running, 1'b0);
    repeat (29) @(negedge clk);
    pulse_start();
    repeat (9) @(negedge clk);
    chk("resume_9", bus.ss, 8'h00);
    @(negedge clk);
    chk("resume_10", bus.ss, 8'h01);

    // Scan sequence showing 12:34.
    do_load(8'h12, 8'h34);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev_an = bus.an;
      @(negedge clk);
      if (prev_an == 4'b0111 && bus.an == 4'b1110) found = 1'b1;
    end
    chk("scan_sync", found, 1'b1);
    chk("d0_an", bus.an, 4'b1110); chk("d0_seg", bus.seg, 7'h4C); chk("d0_dp", bus.dp, 1'b1);
    repeat (4) @(negedge clk);
    chk("d1_an", bus.an, 4'b1101); chk("d1_seg", bus.seg, 7'h06); chk("d1_dp", bus.dp, 1'b1);
    repeat (4) @(negedge clk);
    chk("d2_an", bus.an, 4'b1011); chk("d2_seg", bus.seg, 7'h12); chk("d2_dp", bus.dp, 1'b0);
    repeat (4) @(negedge clk);
    chk("d3_an", bus.an, 4'b0111); chk("d3_seg", bus.seg, 7'h4F); chk("d3_dp", bus.dp, 1'b1);

    // Asynchronous reset mid-run with clear and load also asserted.
    do_load(8'h00, 8'h00);
    bus.dir = 1'b0;
    pulse_start();
    repeat (25) @(negedge clk);
    #2;
    bus.clear = 1'b1; bus.load = 1'b1; bus.load_mm = 8'h12; bus.load_ss = 8'h34;
    arst = 1'b1;
    #1;
    chk("arst_cnt", {bus.mm, bus.ss}, 16'h0000);
    chk("arst_flags", {bus.running, bus.done, bus.err}, 3'b000);
    chk("arst_an", bus.an, 4'hF);
    chk("arst_seg", bus.seg, 7'h7F);
    chk("arst_dp", bus.dp, 1'b1);
    repeat (2) @(negedge clk);
    bus.clear = 1'b0; bus.load = 1'b0;
    arst = 1'b0;
    pulse_start();
    repeat (19) @(negedge clk);
    chk("post_rst_19", {bus.mm, bus.ss}, 16'h0000);
    chk("post_rst_run", bus.running, 1'b1);
    @(negedge clk);
    chk("post_rst_20", {bus.mm, bus.ss}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmss_scan_timer.md
MMSS_SCAN_TIMER -- requirements
Module: mmss_scan_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, count rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer of at least 2.
REQ-003 SHALL have parameter SCAN_HZ, default 1000, digit-advance rate in Hz; CLK_HZ/SCAN_HZ SHALL be an integer of at least 2.
REQ-004 SHALL have parameter AN_ACTIVE_LOW, default 1; 1 means an low selects a digit, 0 inverts an.
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 1; 1 means seg and dp low light a segment, 0 inverts both.
REQ-006 clk  in  1  clock, rising edge.
REQ-007 arst  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  level-sampled each clk; begins or resumes counting.
REQ-009 stop  in  1  pauses counting.
REQ-010 clear  in  1  zeroes the count and returns to IDLE.
REQ-011 load  in  1  presets the count from load_mm and load_ss.
REQ-012 load_mm  in  8  BCD minutes, tens in [7:4], ones in [3:0].
REQ-013 load_ss  in  8  BCD seconds, same layout.
REQ-014 dir  in  1  0 counts up, 1 counts down; sampled on every tick.
REQ-015 seg  out  7  segments a..g, seg[6]=a.
REQ-016 dp  out  1  decimal point.
REQ-017 an  out  4  digit enables; an[0] is seconds ones, an[3] is minutes tens.
REQ-018 mm  out  8  current BCD minutes.
REQ-019 ss  out  8  current BCD seconds.
REQ-020 running  out  1  high in RUN.
REQ-021 done  out  1  high in DONE.
REQ-022 err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-023 States SHALL be IDLE, RUN, PAUSE and DONE.
REQ-024 Command priority within a cycle SHALL be clear > load > stop > start.
REQ-025 clear SHALL set mm=ss=00 and go to IDLE from any state.
REQ-026 A valid load SHALL set mm and ss, go to IDLE and zero the prescaler.
REQ-027 A load SHALL be valid only if every nibble is ≤9 and both tens nibbles are ≤5; an invalid load SHALL leave count and state unchanged and pulse err.
REQ-028 start SHALL take IDLE to RUN (prescaler zeroed) and PAUSE to RUN (prescaler retained); start in DONE SHALL be ignored.
REQ-029 stop in RUN SHALL go to PAUSE; stop in any other state SHALL be ignored.
REQ-030 The prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 only in RUN; a tick SHALL occur in the cycle where it wraps.
REQ-031 On a tick with dir=0, ss SHALL increment BCD-correctly; 59→00 SHALL carry into mm.
REQ-032 On a tick with dir=1, ss SHALL decrement; 00→59 SHALL borrow from mm.
REQ-033 An up-count reaching 59:59, or a down-count reaching 00:00, SHALL enter DONE on the same clk edge as the count update.
REQ-034 In DONE the count SHALL hold and done SHALL stay high until clear or load.
REQ-035 start in RUN with the count already at the terminal value for dir SHALL enter DONE on the next tick without changing the count.
REQ-036 Tick-driven updates SHALL be suppressed in any cycle where clear, load or stop is asserted.
REQ-037 The scan counter SHALL free-run in every state at CLK_HZ/SCAN_HZ clocks per digit and cycle digits 0,1,2,3,0,...
REQ-038 seg, dp and an SHALL be registered: one clk latency from the digit select and digit value.
REQ-039 dp SHALL be lit only on digit 2 (minutes ones).
REQ-040 In PAUSE, dp SHALL blink with a period of one tick, 50% duty.
REQ-041 seg SHALL decode 0-9 to standard patterns; any other nibble SHALL blank the digit.

Reset
REQ-042 While arst is high: state IDLE; mm=ss=00; prescaler and scan counter 0; running=done=err=0; an all-off; seg and dp off (both at the polarity that lights nothing).
REQ-043 Assertion of arst SHALL take effect immediately, including mid-count; release SHALL take effect on the next clk edge.

Structure
REQ-044 Shared package mmss_timer_pkg SHALL hold the state enum, the BCD width and the 10-entry segment pattern table.
REQ-045 A single sub-module seg7_decode SHALL implement the combinational nibble→segment mapping (REQ-041).
REQ-046 Prescaler and scan counters SHALL be sized with $clog2 of their terminal counts.

Verification (CLK_HZ=20, TICK_HZ=1, SCAN_HZ=5)
REQ-047 load 00:58, dir=0, start; after 20 clk → 00:59, after 40 clk → 01:00 with done=0.
REQ-048 load 00:02, dir=1, start; after 40 clk → 00:00 with done=1 and running=0; further start → count unchanged.
REQ-049 load_ss=8'h60 → err pulses one cycle and the count is unchanged; load_mm=8'h0A → same.
REQ-050 RUN for 10 clk, stop for 30 clk, start → next increment occurs 10 clk after resume; dp blinks during PAUSE.
REQ-051 load 12:34 in IDLE → an sequence 0→1→2→3 every 4 clk with seg showing 4,3,2,1 (one clk late); dp only on digit 2.
REQ-052 Assert arst mid-RUN with clear and load also high → all outputs at reset values; after release the first start counts from 00:00.
